// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: register-index sizing and write-latency classes.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

    typedef enum logic {
        LatAlu,
        LatLoad
    } lat_e;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One architectural register's in-flight write count and forwardability countdown.
module scoreboardEntry
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned CNT_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             acc_hit,
    input  lat_e             lat,
    input  logic             wb_hit,
    output logic [CNT_W-1:0] pend_cnt,
    output logic [2:0]       rdy_cnt
);

    logic [CNT_W-1:0] pend_q, pend_d;
    logic [2:0]       rdy_q, rdy_d;

    always_comb begin
        pend_d = pend_q;
        rdy_d  = rdy_q;
        // An issue and a writeback to the same register cancel each other out.
        if (acc_hit && !wb_hit) begin
            pend_d = pend_q + 1'b1;
        end else if (wb_hit && !acc_hit && pend_q != '0) begin
            pend_d = pend_q - 1'b1;
        end
        if (acc_hit) begin
            rdy_d = (lat == LatLoad) ? 3'(LOAD_LAT - 1) : 3'd0;
        end else if (rdy_q != 3'd0) begin
            rdy_d = rdy_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            pend_q <= '0;
            rdy_q  <= '0;
        end else begin
            pend_q <= pend_d;
            rdy_q  <= rdy_d;
        end
    end

    assign pend_cnt = pend_q;
    assign rdy_cnt  = rdy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes, stalls issue on unforwardable sources and flags forwarding.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [REG_IDX_W-1:0] issue_rs1,
    input  logic [REG_IDX_W-1:0] issue_rs2,
    input  logic                 issue_uses_rs1,
    input  logic                 issue_uses_rs2,
    input  logic                 issue_is_load,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    output logic                 stall,
    output logic                 rs1_pending,
    output logic                 rs2_pending,
    output logic [6:0]           inflight,
    output logic                 wb_error
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [CNT_W-1:0] pend_cnt [NUM_REGS];
    logic [2:0]       rdy_cnt  [NUM_REGS];

    logic busy1, busy2, rd_full;
    logic accept, acc_rd, wb_hit, same_rd, wb_zero, inc, dec;
    logic [6:0] inflight_q;
    logic       wb_error_q;

    assign pend_cnt[0] = '0;
    assign rdy_cnt[0]  = '0;

    always_comb begin
        busy1       = issue_uses_rs1 && issue_rs1 != REG_X0 && rdy_cnt[issue_rs1] != 3'd0;
        busy2       = issue_uses_rs2 && issue_rs2 != REG_X0 && rdy_cnt[issue_rs2] != 3'd0;
        rd_full     = issue_rd != REG_X0 && pend_cnt[issue_rd] == PEND_MAX;
        stall       = issue_valid && (busy1 || busy2 || rd_full);
        rs1_pending = issue_uses_rs1 && issue_rs1 != REG_X0 && pend_cnt[issue_rs1] != '0;
        rs2_pending = issue_uses_rs2 && issue_rs2 != REG_X0 && pend_cnt[issue_rs2] != '0;
        accept      = issue_valid && !stall && !flush;
        acc_rd      = accept && issue_rd != REG_X0;
        wb_hit      = !flush && wb_valid && wb_rd != REG_X0;
        same_rd     = acc_rd && wb_hit && issue_rd == wb_rd;
        wb_zero     = wb_hit && pend_cnt[wb_rd] == '0;
        // Mirrors the per-entry count update so the total stays equal to the sum.
        inc         = acc_rd && !same_rd;
        dec         = wb_hit && !same_rd && !wb_zero;
    end

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        scoreboardEntry #(
            .LOAD_LAT (LOAD_LAT),
            .CNT_W    (CNT_W)
        ) u_entry (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .acc_hit  (acc_rd && issue_rd == REG_IDX_W'(r)),
            .lat      (issue_is_load ? LatLoad : LatAlu),
            .wb_hit   (wb_hit && wb_rd == REG_IDX_W'(r)),
            .pend_cnt (pend_cnt[r]),
            .rdy_cnt  (rdy_cnt[r])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            inflight_q <= '0;
        end else if (inc && !dec) begin
            inflight_q <= inflight_q + 7'd1;
        end else if (dec && !inc) begin
            inflight_q <= inflight_q - 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_error_q <= 1'b0;
        end else if (wb_zero) begin
            wb_error_q <= 1'b1;
        end
    end

    assign inflight = inflight_q;
    assign wb_error = wb_error_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized scoreboard bench: a cycle-stamped reference model queues expectations, a monitor checks.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int LL = 2;

    logic       clk = 1'b0;
    logic       reset, flush, issue_valid, issue_uses_rs1, issue_uses_rs2, issue_is_load;
    logic       wb_valid;
    logic [4:0] issue_rd, issue_rs1, issue_rs2, wb_rd;
    logic       stall, rs1_pending, rs2_pending, wb_error;
    logic [6:0] inflight;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .LOAD_LAT (LL),
        .CNT_W    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_uses_rs1 (issue_uses_rs1),
        .issue_uses_rs2 (issue_uses_rs2),
        .issue_is_load  (issue_is_load),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .stall          (stall),
        .rs1_pending    (rs1_pending),
        .rs2_pending    (rs2_pending),
        .inflight       (inflight),
        .wb_error       (wb_error)
    );

    typedef struct packed {
        logic       stall;
        logic       p1;
        logic       p2;
        logic [6:0] infl;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: outstanding-write count per register and the cycle its newest value becomes forwardable.
    int pend[32];
    int ready_at[32];
    int err_m = 0;
    int cyc = 0;
    bit last_stall = 0;

    task automatic cmp(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", nm, act, req, cyc);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("stall", int'(stall), int'(e.stall));
                cmp("rs1_pending", int'(rs1_pending), int'(e.p1));
                cmp("rs2_pending", int'(rs2_pending), int'(e.p2));
                cmp("inflight", int'(inflight), int'(e.infl));
                cmp("wb_error", int'(wb_error), int'(e.err));
            end
        end
    end

    task automatic step(input logic rst, input logic fl, input logic iv, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic ld, input logic wv, input logic [4:0] wrd,
                        input bit chk);
        exp_t e;
        bit   b1, b2, full, st, acc_rd, wb_hit;
        int   s;
        @(posedge clk);
        #1;
        cyc++;
        reset = rst; flush = fl; issue_valid = iv; issue_rd = rd; issue_rs1 = rs1;
        issue_rs2 = rs2; issue_uses_rs1 = u1; issue_uses_rs2 = u2; issue_is_load = ld;
        wb_valid = wv; wb_rd = wrd;

        b1   = u1 && rs1 != 0 && cyc < ready_at[rs1];
        b2   = u2 && rs2 != 0 && cyc < ready_at[rs2];
        full = rd != 0 && pend[rd] == 3;
        st   = iv && (b1 || b2 || full);
        s    = 0;
        for (int i = 0; i < 32; i++) s += pend[i];
        e.stall = st;
        e.p1    = u1 && rs1 != 0 && pend[rs1] != 0;
        e.p2    = u2 && rs2 != 0 && pend[rs2] != 0;
        e.infl  = 7'(s);
        e.err   = (err_m != 0);
        if (chk) exp_q.push_back(e);
        last_stall = st;

        if (rst) begin
            for (int i = 0; i < 32; i++) begin pend[i] = 0; ready_at[i] = 0; end
            err_m = 0;
        end else if (fl) begin
            for (int i = 0; i < 32; i++) begin pend[i] = 0; ready_at[i] = 0; end
        end else begin
            acc_rd = iv && !st && rd != 0;
            wb_hit = wv && wrd != 0;
            if (wb_hit && pend[wrd] == 0) err_m = 1;
            if (acc_rd) ready_at[rd] = cyc + (ld ? LL : 1);
            if (!(acc_rd && wb_hit && rd == wrd)) begin
                if (acc_rd) pend[rd]++;
                if (wb_hit && pend[wrd] > 0) pend[wrd]--;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic wb(input logic [4:0] r);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, r, 1);
    endtask

    initial begin
        logic [4:0] rd, rs1, rs2, wrd;
        logic       iv, u1, u2, ld, wv, rst, fl;
        int         cand[$];

        for (int i = 0; i < 32; i++) begin pend[i] = 0; ready_at[i] = 0; end

        // Reset held with an issue presented on x5.
        step(1, 0, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 5, 0, 1, 0, 0, 0, 0, 1);
        repeat (3) idle();

        // Load x5, dependent add at N+1 stalls, accepted at N+2.
        step(0, 0, 1, 5, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 6, 5, 0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 1, 6, 5, 0, 1, 0, 0, 0, 0, 1);
        wb(5);
        step(0, 0, 1, 0, 5, 6, 1, 1, 0, 1, 6, 1);
        idle();

        // ALU write of x7, reader at N+1 forwards without stalling.
        step(0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 8, 7, 7, 1, 1, 0, 0, 0, 1);
        wb(7);
        wb(8);

        // Four writes to x9: the fourth stalls until a writeback frees a slot.
        repeat (4) step(0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 9, 0, 0, 0, 0, 0, 1, 9, 1);
        step(0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 1);
        wb(9);
        step(0, 0, 1, 9, 9, 0, 1, 0, 0, 1, 9, 1);
        step(0, 0, 1, 10, 9, 0, 1, 0, 0, 0, 0, 1);
        repeat (4) wb(9);
        wb(10);

        // Spurious writeback sets a sticky error that survives flush and clears on reset.
        wb(3);
        idle();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1);
        idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();

        // Three loads in flight, then flush.
        step(0, 0, 1, 10, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 11, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 12, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 1, 1, 13, 12, 11, 1, 1, 1, 1, 10, 1);
        step(0, 0, 1, 0, 12, 11, 1, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        idle();

        // Randomized traffic; a stalled instruction is held until accepted.
        rd = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; ld = 0; iv = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 300) == 0;
            fl  = ($urandom % 60) == 0;
            if (!last_stall) begin
                iv  = ($urandom % 4) != 0;
                rd  = 5'($urandom_range(0, 7));
                rs1 = 5'($urandom_range(0, 7));
                rs2 = 5'($urandom_range(0, 7));
                u1  = 1'($urandom);
                u2  = 1'($urandom);
                ld  = 1'($urandom);
            end
            cand.delete();
            for (int r = 1; r < 32; r++) if (pend[r] > 0) cand.push_back(r);
            wv  = 0;
            wrd = 5'($urandom_range(0, 31));
            if (cand.size() > 0 && ($urandom % 3) != 0) begin
                wv  = 1;
                wrd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
            end else if (($urandom % 80) == 0) begin
                wrd = 5'($urandom_range(8, 31));
                wv  = pend[wrd] == 0;
            end
            step(rst, fl, iv, rd, rs1, rs2, u1, u2, ld, wv, wrd, 1);
        end
        idle();
        idle();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
